// File: rtl/sprite_update_scheduler.sv
// sprite_update_scheduler: round-robin capture of sprite positions, committed to the renderer at vblank.
// Define SPRITE_CLAMP_EN to saturate accepted positions to the playfield and flag clamping.
module sprite_update_scheduler #(
    parameter int NUM_SPRITES = 4,
    parameter int X_W = 10,
    parameter int Y_W = 9,
    parameter int X_MIN = 11,
    parameter int X_MAX = 609,
    parameter int Y_MIN = 21,
    parameter int Y_MAX = 449
) (
    input  logic                     master_clk,
    input  logic                     reset,
    input  logic                     vblank_start,
    input  logic [NUM_SPRITES-1:0]   req,
    input  logic [NUM_SPRITES*X_W-1:0] req_x,
    input  logic [NUM_SPRITES*Y_W-1:0] req_y,
    output logic [NUM_SPRITES-1:0]   grant,
    output logic [NUM_SPRITES*X_W-1:0] active_x,
    output logic [NUM_SPRITES*Y_W-1:0] active_y,
    output logic [NUM_SPRITES-1:0]   active_valid,
    output logic                     commit,
    output logic [15:0]              frame_count,
    output logic                     clamp_hit
);
    localparam int PTR_W = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1;
`ifdef SPRITE_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    typedef enum logic {ACCEPT, COMMIT} state_t;
    state_t state;

    logic [PTR_W-1:0] ptr, idx, winIdx, nextPtr;
    logic found, altered;
    logic [NUM_SPRITES*X_W-1:0] pendX;
    logic [NUM_SPRITES*Y_W-1:0] pendY;
    logic [NUM_SPRITES-1:0] pendDirty;
    logic [X_W-1:0] selX, accX;
    logic [Y_W-1:0] selY, accY;

    // Rotating priority: first requester at or above the pointer wins.
    always_comb begin
        found = 1'b0;
        winIdx = '0;
        idx = '0;
        for (int k = 0; k < NUM_SPRITES; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_SPRITES);
            if (!found && req[idx]) begin
                found = 1'b1;
                winIdx = idx;
            end
        end
        nextPtr = (int'(winIdx) == NUM_SPRITES - 1) ? '0 : winIdx + 1'b1;
        selX = req_x[int'(winIdx)*X_W +: X_W];
        selY = req_y[int'(winIdx)*Y_W +: Y_W];
        accX = !CLAMP_EN ? selX : selX < X_W'(X_MIN) ? X_W'(X_MIN) : selX > X_W'(X_MAX) ? X_W'(X_MAX) : selX;
        accY = !CLAMP_EN ? selY : selY < Y_W'(Y_MIN) ? Y_W'(Y_MIN) : selY > Y_W'(Y_MAX) ? Y_W'(Y_MAX) : selY;
        altered = (accX != selX) || (accY != selY);
    end

    always_ff @(posedge master_clk) begin
        if (reset) begin
            state <= ACCEPT;
            ptr <= '0;
            grant <= '0;
            commit <= 1'b0;
            pendX <= '0;
            pendY <= '0;
            pendDirty <= '0;
            active_x <= '0;
            active_y <= '0;
            active_valid <= '0;
            frame_count <= '0;
            clamp_hit <= 1'b0;
        end else begin
            grant <= '0;
            commit <= 1'b0;
            if (state == COMMIT) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    if (pendDirty[i]) begin
                        active_x[i*X_W +: X_W] <= pendX[i*X_W +: X_W];
                        active_y[i*Y_W +: Y_W] <= pendY[i*Y_W +: Y_W];
                    end
                end
                active_valid <= active_valid | pendDirty;
                pendDirty <= '0;
                commit <= 1'b1;
                frame_count <= frame_count + 16'd1;
                state <= ACCEPT;
            end else if (vblank_start) begin
                state <= COMMIT;
            end else if (found) begin
                grant <= NUM_SPRITES'(1) << winIdx;
                pendX[int'(winIdx)*X_W +: X_W] <= accX;
                pendY[int'(winIdx)*Y_W +: Y_W] <= accY;
                pendDirty[winIdx] <= 1'b1;
                ptr <= nextPtr;
                clamp_hit <= clamp_hit | altered;
            end
        end
    end
endmodule

// File: tb/tb_sprite_update_scheduler.sv
// tb_sprite_update_scheduler: directed and random checks against a frame-level bank model.
// Build with SPRITE_CLAMP_EN defined to exercise clamping.
module tb_sprite_update_scheduler;
    localparam int N = 4;
    localparam int XW = 10;
    localparam int YW = 9;

    logic master_clk = 1'b0;
    logic reset = 1'b1;
    logic vblank_start = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*XW-1:0] req_x = '0;
    logic [N*YW-1:0] req_y = '0;
    logic [N-1:0] grant;
    logic [N*XW-1:0] active_x;
    logic [N*YW-1:0] active_y;
    logic [N-1:0] active_valid;
    logic commit;
    logic [15:0] frame_count;
    logic clamp_hit;

    sprite_update_scheduler dut (
        .master_clk(master_clk), .reset(reset), .vblank_start(vblank_start),
        .req(req), .req_x(req_x), .req_y(req_y), .grant(grant),
        .active_x(active_x), .active_y(active_y), .active_valid(active_valid),
        .commit(commit), .frame_count(frame_count), .clamp_hit(clamp_hit)
    );

    always #5 master_clk = ~master_clk;

    int nAsserts = 0;
    int nFails = 0;

    int mActX[N], mActY[N], mPendX[N], mPendY[N];
    bit mDirty[N], mValid[N];
    int mPtr = 0;
    int mFrame = 0;
    bit mInCommit = 0;
    bit mClamp = 0;
    bit mCommit = 0;
    logic [N-1:0] mGrant = '0;

    function automatic int clampV(int v, int lo, int hi);
`ifdef SPRITE_CLAMP_EN
        return v < lo ? lo : (v > hi ? hi : v);
`else
        return v;
`endif
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the frame model: reset, frame commit, vblank, or one accepted post.
    task automatic modelEdge();
        int w, x, y, cx, cy;
        mGrant = '0;
        mCommit = 0;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                mActX[i] = 0; mActY[i] = 0; mPendX[i] = 0; mPendY[i] = 0;
                mDirty[i] = 0; mValid[i] = 0;
            end
            mPtr = 0; mFrame = 0; mInCommit = 0; mClamp = 0;
        end else if (mInCommit) begin
            for (int i = 0; i < N; i++) begin
                if (mDirty[i]) begin
                    mActX[i] = mPendX[i];
                    mActY[i] = mPendY[i];
                    mValid[i] = 1;
                end
                mDirty[i] = 0;
            end
            mCommit = 1;
            mFrame = (mFrame + 1) % 65536;
            mInCommit = 0;
        end else if (vblank_start) begin
            mInCommit = 1;
        end else begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && ((req >> ((mPtr + k) % N)) & 1) != 0) w = (mPtr + k) % N;
            if (w >= 0) begin
                x = int'(XW'(req_x >> (w * XW)));
                y = int'(YW'(req_y >> (w * YW)));
                cx = clampV(x, 11, 609);
                cy = clampV(y, 21, 449);
                if (cx != x || cy != y) mClamp = 1;
                mPendX[w] = cx;
                mPendY[w] = cy;
                mDirty[w] = 1;
                mGrant = N'(1) << w;
                mPtr = (w + 1) % N;
            end
        end
    endtask

    task automatic compareAll();
        logic [N*XW-1:0] ex;
        logic [N*YW-1:0] ey;
        logic [N-1:0] ev;
        for (int i = 0; i < N; i++) begin
            ex[i*XW +: XW] = XW'(mActX[i]);
            ey[i*YW +: YW] = YW'(mActY[i]);
            ev[i] = mValid[i];
        end
        check("grant", 64'(grant), 64'(mGrant));
        check("commit", 64'(commit), 64'(mCommit));
        check("active_x", 64'(active_x), 64'(ex));
        check("active_y", 64'(active_y), 64'(ey));
        check("active_valid", 64'(active_valid), 64'(ev));
        check("frame_count", 64'(frame_count), 64'(mFrame));
        check("clamp_hit", 64'(clamp_hit), 64'(mClamp));
    endtask

    task automatic tick();
        @(posedge master_clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    logic [N-1:0] rrSeq[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        tick();
        tick();
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_frame", 64'(frame_count), 64'd0);
        check("rst_valid", 64'(active_valid), 64'd0);
        reset = 1'b0;

        // Single post, committed at vblank
        req = 4'b0001; req_x[9:0] = 10'd100; req_y[8:0] = 9'd200;
        tick();
        check("tp1_grant", 64'(grant), 64'h1);
        req = '0;
        tick();
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        check("tp1_hold_x", 64'(active_x[9:0]), 64'd0);
        tick();
        check("tp1_commit", 64'(commit), 64'd1);
        check("tp1_x", 64'(active_x[9:0]), 64'd100);
        check("tp1_y", 64'(active_y[8:0]), 64'd200);
        check("tp1_valid", 64'(active_valid), 64'h1);
        check("tp1_frame", 64'(frame_count), 64'd1);

        // Round robin from pointer 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_x[i*XW +: XW] = XW'(100 + i * 111);
            req_y[i*YW +: YW] = YW'(50 + i * 10);
        end
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_grant", 64'(grant), 64'(rrSeq[i]));
        end
        req = '0;
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        tick();

        // Overwrite within a frame; sprite 1 untouched
        req = 4'b0100; req_x[29:20] = 10'd50;
        tick();
        req_x[29:20] = 10'd60;
        tick();
        req = '0;
        tick();
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        tick();
        check("ow_x2", 64'(active_x[29:20]), 64'd60);
        check("ow_x1_kept", 64'(active_x[19:10]), 64'd211);

        // Request coinciding with vblank waits a frame
        req = 4'b0010; req_x[19:10] = 10'd500; vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        check("vb_nogrant", 64'(grant), 64'd0);
        tick();
        check("vb_commit", 64'(commit), 64'd1);
        check("vb_commit_nogrant", 64'(grant), 64'd0);
        tick();
        check("vb_late_grant", 64'(grant), 64'h2);
        req = '0;
        tick();
        check("vb_not_yet", 64'(active_x[19:10]), 64'd211);
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        tick();
        check("vb_next_frame", 64'(active_x[19:10]), 64'd500);

        // Out-of-range post
        req = 4'b1000; req_x[39:30] = 10'd5; req_y[35:27] = 9'd470;
        tick();
        req = '0;
        tick();
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        tick();
`ifdef SPRITE_CLAMP_EN
        check("clamp_x", 64'(active_x[39:30]), 64'd11);
        check("clamp_y", 64'(active_y[35:27]), 64'd449);
        check("clamp_flag", 64'(clamp_hit), 64'd1);
`else
        check("clamp_x", 64'(active_x[39:30]), 64'd5);
        check("clamp_y", 64'(active_y[35:27]), 64'd470);
        check("clamp_flag", 64'(clamp_hit), 64'd0);
`endif

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            vblank_start = ($urandom_range(0, 14) == 0);
            req = N'($urandom);
            req_x = {$urandom, $urandom};
            req_y = {$urandom, $urandom};
            tick();
        end
        reset = 1'b0; vblank_start = 1'b0; req = '0;

        // Reset discards pending posts
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b0001;
        tick();
        req = 4'b0100;
        tick();
        req = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        tick();
        check("rst_mid_valid", 64'(active_valid), 64'd0);
        check("rst_mid_frame", 64'(frame_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
